// File: rtl/user_register_bank.sv
// user_register_bank
//   Bank of NREGS general-purpose registers for the 19-bit CPU datapath.
//   One register is modified per clock by LOAD/INC/DEC/CLR, or all of them
//   are zeroed by CLRALL. Two combinational read ports feed the ALU and the
//   address logic. Status flags are registered and describe the most recent
//   operation that took effect.
//
//   Build option: define UREG_SATURATE_EN to make INC/DEC saturate at
//   all-ones/zero instead of wrapping. CARRY/BORROW flag the event in both
//   builds.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   opAddr            target register for LOAD/INC/DEC/CLR
//   inpData           LOAD data
//   LOAD/INC/DEC/CLR  single-register operations (LOAD > INC > DEC > CLR)
//   CLRALL            clear every register (highest priority)
//   rdAddrA/B         read addresses; out-of-range reads return 0
//   opDataA/B         read data
//   ZERO              last result was 0
//   CARRY/BORROW      last INC overflowed / last DEC underflowed
//   ADDR_ERR          last operation targeted a nonexistent register
module user_register_bank #(
  parameter int WIDTH = 19,
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [AW-1:0]    opAddr,
  input  logic [WIDTH-1:0] inpData,
  input  logic             LOAD,
  input  logic             INC,
  input  logic             DEC,
  input  logic             CLR,
  input  logic             CLRALL,
  input  logic [AW-1:0]    rdAddrA,
  input  logic [AW-1:0]    rdAddrB,
  output logic [WIDTH-1:0] opDataA,
  output logic [WIDTH-1:0] opDataB,
  output logic             ZERO,
  output logic             CARRY,
  output logic             BORROW,
  output logic             ADDR_ERR
);

  // One extra bit so NREGS == 2^AW is representable.
  localparam logic [AW:0]      NREGS_W = (AW+1)'(NREGS);
  localparam logic [WIDTH-1:0] ONES    = '1;

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic zero_q, zero_d;
  logic carry_q, carry_d;
  logic borrow_q, borrow_d;
  logic err_q, err_d;

  logic             op_any;
  logic             addr_ok;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] new_val;
  logic             ovf_c, ovf_b;

  // Compare-based mux: addresses that match no entry fall through to 0,
  // which gives the out-of-range read behaviour for free.
  function automatic logic [WIDTH-1:0] rd_mux(
    input logic [AW-1:0]                a,
    input logic [NREGS-1:0][WIDTH-1:0] arr
  );
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++)
      if (a == AW'(i)) r = arr[i];
    return r;
  endfunction

  assign op_any  = LOAD | INC | DEC | CLR;
  assign addr_ok = {1'b0, opAddr} < NREGS_W;
  assign cur     = rd_mux(opAddr, regs_q);

  // Result of the single-register operation, by priority.
  always_comb begin
    new_val = '0;
    ovf_c   = 1'b0;
    ovf_b   = 1'b0;
    if (LOAD) begin
      new_val = inpData;
    end else if (INC) begin
      if (cur == ONES) begin
        ovf_c = 1'b1;
`ifdef UREG_SATURATE_EN
        new_val = ONES;
`else
        new_val = '0;
`endif
      end else begin
        new_val = cur + WIDTH'(1);
      end
    end else if (DEC) begin
      if (cur == '0) begin
        ovf_b = 1'b1;
`ifdef UREG_SATURATE_EN
        new_val = '0;
`else
        new_val = ONES;
`endif
      end else begin
        new_val = cur - WIDTH'(1);
      end
    end
    // CLR leaves new_val at 0
  end

  always_comb begin
    regs_d   = regs_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    if (CLRALL) begin
      regs_d   = '0;
      zero_d   = 1'b1;
      carry_d  = 1'b0;
      borrow_d = 1'b0;
      err_d    = 1'b0;
    end else if (op_any) begin
      if (!addr_ok) begin
        // Bad target: nothing written, only ADDR_ERR moves.
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < NREGS; i++)
          if (opAddr == AW'(i)) regs_d[i] = new_val;
        zero_d   = (new_val == '0);
        carry_d  = ovf_c;
        borrow_d = ovf_b;
        err_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      regs_q   <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  // Reads come from the stored array, so a same-cycle write is not visible.
  assign opDataA  = rd_mux(rdAddrA, regs_q);
  assign opDataB  = rd_mux(rdAddrB, regs_q);
  assign ZERO     = zero_q;
  assign CARRY    = carry_q;
  assign BORROW   = borrow_q;
  assign ADDR_ERR = err_q;

endmodule

// File: tb/tb_user_register_bank.sv
module tb_user_register_bank;

  localparam int W  = 19;
  localparam int NR = 6;
  localparam int AW = 3;

  // op encoding {CLRALL, LOAD, INC, DEC, CLR}
  localparam logic [4:0] NOP = 5'b00000, OCLR = 5'b00001, ODEC = 5'b00010,
                         OINC = 5'b00100, OLD  = 5'b01000, OCA  = 5'b10000;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] opAddr = '0;
  logic [W-1:0]  inpData = '0;
  logic          LOAD = 0, INC = 0, DEC = 0, CLR = 0, CLRALL = 0;
  logic [AW-1:0] rdAddrA = '0, rdAddrB = '0;
  logic [W-1:0]  opDataA, opDataB;
  logic          ZERO, CARRY, BORROW, ADDR_ERR;

  user_register_bank #(.WIDTH(W), .NREGS(NR), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .opAddr(opAddr), .inpData(inpData),
    .LOAD(LOAD), .INC(INC), .DEC(DEC), .CLR(CLR), .CLRALL(CLRALL),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .opDataA(opDataA), .opDataB(opDataB),
    .ZERO(ZERO), .CARRY(CARRY), .BORROW(BORROW), .ADDR_ERR(ADDR_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    int          due;
    logic [W-1:0] ea, eb;
    logic [3:0]  ef;   // {ZERO, CARRY, BORROW, ADDR_ERR}
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: outputs settle after each edge; compare at the falling edge.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      exp_t s;
      s = sb.pop_front();
      tests++; fails++;
      $display("FAIL %s: check missed (due %0d, now %0d)", s.nm, s.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      logic [3:0] gf;
      e  = sb.pop_front();
      gf = {ZERO, CARRY, BORROW, ADDR_ERR};
      tests++;
      if (opDataA !== e.ea || opDataB !== e.eb || gf !== e.ef) begin
        fails++;
        $display("FAIL %s: got A=%h B=%h flags=%b, expected A=%h B=%h flags=%b",
                 e.nm, opDataA, opDataB, gf, e.ea, e.eb, e.ef);
      end
    end
  end

  // One cycle of stimulus: the expectation describes the outputs this cycle
  // (state after the previous edge, read through ra/rb); op takes effect at
  // the next edge. pulse asserts RST across the check and releases it before
  // that edge.
  task automatic step(input string nm, input logic [4:0] op, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [W-1:0] ea, input logic [W-1:0] eb, input logic [3:0] ef,
                      input bit pulse = 1'b0);
    exp_t e;
    @(posedge CLK);
    #2;
    {CLRALL, LOAD, INC, DEC, CLR} = op;
    opAddr  = a;
    inpData = d;
    rdAddrA = ra;
    rdAddrB = rb;
    if (pulse) RST = 1'b1;
    e.nm = nm; e.due = cyc; e.ea = ea; e.eb = eb; e.ef = ef;
    sb.push_back(e);
    if (pulse) begin
      #5;
      RST = 1'b0;
    end
  endtask

`ifdef UREG_SATURATE_EN
  localparam logic [W-1:0] R1_INC = 19'h7FFFF;  // saturated
  localparam logic [3:0]   F_INC  = 4'b0100;
  localparam logic [W-1:0] R5_DEC = 19'h00000;
  localparam logic [3:0]   F_DEC  = 4'b1010;
`else
  localparam logic [W-1:0] R1_INC = 19'h00000;  // wrapped
  localparam logic [3:0]   F_INC  = 4'b1100;
  localparam logic [W-1:0] R5_DEC = 19'h7FFFF;
  localparam logic [3:0]   F_DEC  = 4'b0010;
`endif

  initial begin
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;

    step("reset",     NOP,           0, 0,        3, 2, 0,        0,        4'b1000);
    step("ld_r3",     OLD,           3, 19'h12345, 3, 2, 0,       0,        4'b1000);
    step("r3_load",   NOP,           0, 0,        3, 2, 19'h12345, 0,       4'b0000);
    step("r4_hold",   OLD,           1, 19'h7FFFF, 4, 3, 0,       19'h12345, 4'b0000);
    step("r1_load",   OINC,          1, 0,        1, 4, 19'h7FFFF, 0,       4'b0000);
    step("inc_ovf",   OCLR,          5, 0,        1, 5, R1_INC,   0,        F_INC);
    step("clr_r5",    ODEC,          5, 0,        5, 1, 0,        R1_INC,   4'b1000);
    step("dec_ovf",   OLD,           2, 19'd10,   5, 1, R5_DEC,   R1_INC,   F_DEC);
    step("ld_r2",     OLD|OINC|ODEC, 2, 19'h00ABC, 2, 5, 19'd10,  R5_DEC,   4'b0000);
    step("ld_pri",    OINC|ODEC,     2, 19'h11111, 2, 3, 19'h00ABC, 19'h12345, 4'b0000);
    step("inc_pri",   OCA|OLD,       3, 19'h55555, 2, 3, 19'h00ABD, 19'h12345, 4'b0000);
    step("clrall",    OLD,           7, 19'd1,    3, 2, 0,        0,        4'b1000);
    step("addr_err",  ODEC,          6, 0,        7, 0, 0,        0,        4'b1001);
    step("err_hold",  OLD,           0, 19'd3,    7, 6, 0,        0,        4'b1001);
    step("err_clr",   OINC,          4, 0,        0, 7, 19'd3,    0,        4'b0000);
    step("chain_1",   OINC,          4, 0,        4, 0, 19'd1,    19'd3,    4'b0000);
    step("chain_2",   ODEC,          4, 0,        4, 0, 19'd2,    19'd3,    4'b0000);
    step("chain_net", NOP,           0, 0,        4, 0, 19'd1,    19'd3,    4'b0000);
    step("idle_hold", OINC,          0, 0,        4, 0, 19'd1,    19'd3,    4'b0000);
    step("inc_r0",    OINC,          0, 0,        0, 4, 19'd4,    19'd1,    4'b0000);
    step("rst_async", OINC,          0, 0,        0, 4, 0,        0,        4'b1000, 1'b1);
    step("post_rst1", OINC,          0, 0,        0, 4, 19'd1,    0,        4'b0000);
    step("post_rst2", NOP,           0, 0,        0, 4, 19'd2,    0,        4'b0000);

    repeat (3) @(posedge CLK);
    #5;
    while (sb.size() > 0) begin
      exp_t s;
      s = sb.pop_front();
      tests++; fails++;
      $display("FAIL %s: check never reached", s.nm);
    end
    tests++;
    if (opDataA !== 19'd2) begin
      fails++;
      $display("FAIL final_r0: got %h, expected %h", opDataA, 19'd2);
    end
    tests++;
    if (opDataB !== 19'd0) begin
      fails++;
      $display("FAIL final_r4: got %h, expected %h", opDataB, 19'd0);
    end
    tests++;
    if ({ZERO, CARRY, BORROW, ADDR_ERR} !== 4'b0000) begin
      fails++;
      $display("FAIL final_flags: got %b, expected 0000", {ZERO, CARRY, BORROW, ADDR_ERR});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
